// File: rtl/cop_pkg.sv
// Shared constants for the coprocessor dispatch path: instruction field
// positions and the opcode/hint widths carried with every command.
package cop_pkg;

    localparam int unsigned OPCODE_W     = 5;
    localparam int unsigned HINT_W       = 8;
    localparam int unsigned INSN_W       = 32;

    // Instruction word fields
    localparam int unsigned INSN_VLD_BIT = 12;
    localparam int unsigned INSN_FN_HI   = 29;
    localparam int unsigned INSN_FN_LO   = 25;
    localparam int unsigned INSN_XS_HI   = 14;
    localparam int unsigned INSN_XS_LO   = 13;

endpackage

// File: rtl/cop_sync_fifo.sv
// Single-clock FIFO with full/empty flags. Pointers carry one extra wrap bit
// so that full and empty are distinguishable without a separate counter.
module cop_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             push_en, pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem[rd_ptr_q[AW-1:0]];

    // Pointer state; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cop_dispatch_queue.sv
// Coprocessor dispatch queue: accepts CPU requests, queues legal ones for the
// accelerator, limits commands in flight, and returns accelerator responses or
// locally generated decode-error responses to the CPU.
// Optional macro COP_DISPATCH_PERF_EN adds perf_cmd_cnt / perf_stall_cnt.
module cop_dispatch_queue
    import cop_pkg::*;
#(
    parameter int unsigned ID_WIDTH        = 12,
    parameter int unsigned REQ_DATA_WIDTH  = 256,
    parameter int unsigned RESP_DATA_WIDTH = 64,
    parameter int unsigned REQ_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pad_cop_req_vld,
    output logic                       cop_pad_req_rdy,
    input  logic [OPCODE_W-1:0]        pad_cop_req_cop,
    input  logic [HINT_W-1:0]          pad_cop_req_hint,
    input  logic [ID_WIDTH-1:0]        pad_cop_req_id,
    input  logic [INSN_W-1:0]          pad_cop_req_insn,
    input  logic [REQ_DATA_WIDTH-1:0]  pad_cop_req_data,
    output logic                       accel_cmd_valid,
    output logic [OPCODE_W-1:0]        accel_cmd_opcode,
    output logic [HINT_W-1:0]          accel_cmd_hint,
    output logic [ID_WIDTH-1:0]        accel_cmd_id,
    output logic [INSN_W-1:0]          accel_cmd_insn,
    output logic [REQ_DATA_WIDTH-1:0]  accel_cmd_data,
    input  logic                       accel_cmd_ready,
    input  logic                       accel_resp_valid,
    input  logic [ID_WIDTH-1:0]        accel_resp_id,
    input  logic [RESP_DATA_WIDTH-1:0] accel_resp_data,
    output logic                       cop_pad_resp_vld,
    output logic [ID_WIDTH-1:0]        cop_pad_resp_id,
    output logic [RESP_DATA_WIDTH-1:0] cop_pad_resp_data,
    output logic                       cop_pad_resp_err,
    output logic [7:0]                 outstanding_cnt,
`ifdef COP_DISPATCH_PERF_EN
    output logic [31:0]                perf_cmd_cnt,
    output logic [31:0]                perf_stall_cnt,
`endif
    output logic                       err_underflow
);

    localparam int unsigned EW = OPCODE_W + HINT_W + ID_WIDTH + INSN_W + REQ_DATA_WIDTH;

    logic [EW-1:0]              fifo_wdata, fifo_rdata;
    logic                       fifo_full, fifo_empty, fifo_push;
    logic                       req_hs, req_legal, cmd_hs;

    logic [7:0]                 cnt_q, cnt_d;
    logic                       underflow_q, underflow_d;
    logic                       err_pending_q, err_pending_d;
    logic [ID_WIDTH-1:0]        err_id_q, err_id_d;
    logic                       resp_vld_q, resp_vld_d;
    logic [ID_WIDTH-1:0]        resp_id_q, resp_id_d;
    logic [RESP_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                       resp_err_q, resp_err_d;

    assign cop_pad_req_rdy = !fifo_full && !err_pending_q;
    assign req_hs          = pad_cop_req_vld && cop_pad_req_rdy;
    assign req_legal       = pad_cop_req_insn[INSN_VLD_BIT];
    assign fifo_push       = req_hs && req_legal;
    assign fifo_wdata      = {pad_cop_req_cop, pad_cop_req_hint, pad_cop_req_id,
                              pad_cop_req_insn, pad_cop_req_data};

    assign accel_cmd_valid = !fifo_empty && (cnt_q < 8'(MAX_OUTSTANDING));
    assign cmd_hs          = accel_cmd_valid && accel_cmd_ready;
    assign {accel_cmd_opcode, accel_cmd_hint, accel_cmd_id,
            accel_cmd_insn, accel_cmd_data} = fifo_rdata;

    cop_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (cmd_hs),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outstanding count and underflow flag next-state.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        case ({cmd_hs, accel_resp_valid})
            2'b10:   cnt_d = cnt_q + 8'd1;
            2'b01:   if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            default: ;
        endcase
        if (accel_resp_valid && (cnt_q == 8'd0)) underflow_d = 1'b1;
    end

    // Response path: accelerator responses win; a pending decode error waits.
    always_comb begin
        err_pending_d = err_pending_q;
        err_id_d      = err_id_q;
        resp_vld_d    = 1'b0;
        resp_id_d     = resp_id_q;
        resp_data_d   = resp_data_q;
        resp_err_d    = resp_err_q;
        if (req_hs && !req_legal) begin
            err_pending_d = 1'b1;
            err_id_d      = pad_cop_req_id;
        end
        if (accel_resp_valid) begin
            resp_vld_d  = 1'b1;
            resp_id_d   = accel_resp_id;
            resp_data_d = accel_resp_data;
            resp_err_d  = 1'b0;
        end else if (err_pending_q) begin
            resp_vld_d    = 1'b1;
            resp_id_d     = err_id_q;
            resp_data_d   = '0;
            resp_err_d    = 1'b1;
            err_pending_d = 1'b0;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            underflow_q   <= 1'b0;
            err_pending_q <= 1'b0;
            err_id_q      <= '0;
            resp_vld_q    <= 1'b0;
            resp_id_q     <= '0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            underflow_q   <= underflow_d;
            err_pending_q <= err_pending_d;
            err_id_q      <= err_id_d;
            resp_vld_q    <= resp_vld_d;
            resp_id_q     <= resp_id_d;
            resp_data_q   <= resp_data_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign outstanding_cnt   = cnt_q;
    assign err_underflow     = underflow_q;
    assign cop_pad_resp_vld  = resp_vld_q;
    assign cop_pad_resp_id   = resp_id_q;
    assign cop_pad_resp_data = resp_data_q;
    assign cop_pad_resp_err  = resp_err_q;

`ifdef COP_DISPATCH_PERF_EN
    logic [31:0] perf_cmd_q, perf_stall_q;

    // Free-running wrapping counters of handshakes and stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cmd_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (cmd_hs) perf_cmd_q <= perf_cmd_q + 32'd1;
            if (accel_cmd_valid && !accel_cmd_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_cmd_cnt   = perf_cmd_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_cop_dispatch_queue.sv
// Directed bench for cop_dispatch_queue, built with MAX_OUTSTANDING=2.
// Inputs change and outputs are sampled just after the falling edge.
module tb_cop_dispatch_queue;

    localparam int IDW = 12;
    localparam int RQW = 256;
    localparam int RSW = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_vld, req_rdy;
    logic [4:0]     req_cop;
    logic [7:0]     req_hint;
    logic [IDW-1:0] req_id;
    logic [31:0]    req_insn;
    logic [RQW-1:0] req_data;
    logic           cmd_valid, cmd_ready;
    logic [4:0]     cmd_opcode;
    logic [7:0]     cmd_hint;
    logic [IDW-1:0] cmd_id;
    logic [31:0]    cmd_insn;
    logic [RQW-1:0] cmd_data;
    logic           a_resp_valid;
    logic [IDW-1:0] a_resp_id;
    logic [RSW-1:0] a_resp_data;
    logic           resp_vld, resp_err, underflow;
    logic [IDW-1:0] resp_id;
    logic [RSW-1:0] resp_data;
    logic [7:0]     cnt;
`ifdef COP_DISPATCH_PERF_EN
    logic [31:0]    perf_cmd, perf_stall;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cop_dispatch_queue #(
        .ID_WIDTH        (IDW),
        .REQ_DATA_WIDTH  (RQW),
        .RESP_DATA_WIDTH (RSW),
        .REQ_DEPTH       (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pad_cop_req_vld   (req_vld),
        .cop_pad_req_rdy   (req_rdy),
        .pad_cop_req_cop   (req_cop),
        .pad_cop_req_hint  (req_hint),
        .pad_cop_req_id    (req_id),
        .pad_cop_req_insn  (req_insn),
        .pad_cop_req_data  (req_data),
        .accel_cmd_valid   (cmd_valid),
        .accel_cmd_opcode  (cmd_opcode),
        .accel_cmd_hint    (cmd_hint),
        .accel_cmd_id      (cmd_id),
        .accel_cmd_insn    (cmd_insn),
        .accel_cmd_data    (cmd_data),
        .accel_cmd_ready   (cmd_ready),
        .accel_resp_valid  (a_resp_valid),
        .accel_resp_id     (a_resp_id),
        .accel_resp_data   (a_resp_data),
        .cop_pad_resp_vld  (resp_vld),
        .cop_pad_resp_id   (resp_id),
        .cop_pad_resp_data (resp_data),
        .cop_pad_resp_err  (resp_err),
        .outstanding_cnt   (cnt),
`ifdef COP_DISPATCH_PERF_EN
        .perf_cmd_cnt      (perf_cmd),
        .perf_stall_cnt    (perf_stall),
`endif
        .err_underflow     (underflow)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [RQW-1:0] data_of(input logic [IDW-1:0] id);
        logic [31:0] w;
        w = {20'h0, id};
        return {8{w}};
    endfunction

    task automatic drive_req(input logic [IDW-1:0] id, input logic [31:0] insn);
        req_vld  = 1'b1;
        req_id   = id;
        req_insn = insn;
        req_cop  = id[4:0];
        req_hint = 8'h40 | 8'(id);
        req_data = data_of(id);
    endtask

    task automatic drive_resp(input logic [IDW-1:0] id, input logic [RSW-1:0] d);
        a_resp_valid = 1'b1;
        a_resp_id    = id;
        a_resp_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        req_vld = 1'b0; req_cop = '0; req_hint = '0; req_id = '0; req_insn = '0; req_data = '0;
        cmd_ready = 1'b0; a_resp_valid = 1'b0; a_resp_id = '0; a_resp_data = '0;

        // Reset state
        tick();
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cnt", cnt, 0);
        check("rst_resp_vld", resp_vld, 0);
        check("rst_underflow", underflow, 0);
        check("rst_rdy", req_rdy, 1);
        rst = 1'b0;

        // Fill the FIFO with the accelerator stalled
        for (int i = 1; i <= 4; i++) begin
            drive_req(12'(i), 32'h0000_1000 | 32'(i));
            tick();
        end
        req_vld = 1'b0;
        check("full_rdy", req_rdy, 0);
        check("stall_valid", cmd_valid, 1);
        check("stall_id", cmd_id, 1);
        check("stall_opcode", cmd_opcode, 1);
        check("stall_hint", cmd_hint, 8'h41);
        check("stall_insn", cmd_insn, 32'h1001);
        check("stall_data", cmd_data, data_of(12'd1));
        tick();
        check("stall_hold_id", cmd_id, 1);
        check("stall_cnt", cnt, 0);

        // Release: commands issue in order, capped at two outstanding
        cmd_ready = 1'b1;
        tick();
        check("issue2_id", cmd_id, 2);
        check("issue1_cnt", cnt, 1);
        tick();
        check("cap_valid", cmd_valid, 0);
        check("cap_cnt", cnt, 2);
        check("cap_head_id", cmd_id, 3);
        drive_resp(12'd1, 64'hA1);
        tick();
        a_resp_valid = 1'b0;
        check("resp1_vld", resp_vld, 1);
        check("resp1_id", resp_id, 1);
        check("resp1_data", resp_data, 64'hA1);
        check("resp1_err", resp_err, 0);
        check("resp1_cnt", cnt, 1);
        check("uncap_valid", cmd_valid, 1);
        tick();
        check("resp_pulse", resp_vld, 0);
        check("resp_hold_id", resp_id, 1);
        check("issue3_cnt", cnt, 2);
        check("issue4_head", cmd_id, 4);
        drive_resp(12'd2, 64'hB2);
        tick();
        a_resp_valid = 1'b0;
        check("resp2_cnt", cnt, 1);
        check("ready4_valid", cmd_valid, 1);
        // Handshake and response in the same cycle
        drive_resp(12'd3, 64'hC3);
        tick();
        a_resp_valid = 1'b0;
        check("both_cnt", cnt, 1);
        check("both_resp_vld", resp_vld, 1);
        check("both_resp_id", resp_id, 3);
        check("both_resp_data", resp_data, 64'hC3);
        check("drained_valid", cmd_valid, 0);
        drive_resp(12'd4, 64'hD4);
        tick();
        a_resp_valid = 1'b0;
        cmd_ready = 1'b0;
        check("resp4_cnt", cnt, 0);
        check("resp4_id", resp_id, 4);
        tick();
        check("idle_resp_vld", resp_vld, 0);

        // Illegal instruction yields a local error response
        drive_req(12'h7, 32'h0000_0000);
        tick();
        req_vld = 1'b0;
        check("ill_no_cmd", cmd_valid, 0);
        check("ill_rdy_blocked", req_rdy, 0);
        check("ill_no_resp_yet", resp_vld, 0);
        tick();
        check("ill_resp_vld", resp_vld, 1);
        check("ill_resp_id", resp_id, 12'h7);
        check("ill_resp_data", resp_data, 0);
        check("ill_resp_err", resp_err, 1);
        check("ill_rdy_back", req_rdy, 1);
        tick();
        check("ill_pulse", resp_vld, 0);

        // Error pending collides with an (underflowing) accelerator response
        drive_req(12'h9, 32'hFFFF_EFFF);
        tick();
        req_vld = 1'b0;
        drive_resp(12'h5, 64'h55);
        tick();
        a_resp_valid = 1'b0;
        check("coll_resp_id", resp_id, 12'h5);
        check("coll_resp_err", resp_err, 0);
        check("uflow_set", underflow, 1);
        check("uflow_cnt", cnt, 0);
        tick();
        check("coll_err_vld", resp_vld, 1);
        check("coll_err_id", resp_id, 12'h9);
        check("coll_err_err", resp_err, 1);
        check("coll_err_data", resp_data, 0);
        tick();
        tick();
        check("uflow_sticky", underflow, 1);
        check("uflow_cnt_hold", cnt, 0);

        // Mid-operation reset with queued and in-flight work
        drive_req(12'hA, 32'h1000); tick();
        drive_req(12'hB, 32'h1000); tick();
        drive_req(12'hC, 32'h1000); tick();
        drive_req(12'hD, 32'h1000);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        req_vld = 1'b0;
        check("pre_rst_cnt", cnt, 1);
        check("pre_rst_head", cmd_id, 12'hB);
        check("pre_rst_valid", cmd_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", cmd_valid, 0);
        check("arst_cnt", cnt, 0);
        check("arst_uflow", underflow, 0);
        check("arst_resp_id", resp_id, 0);
        tick();
        rst = 1'b0;
        check("post_rst_rdy", req_rdy, 1);
        tick();
        check("post_rst_valid", cmd_valid, 0);
        drive_resp(12'h1, 64'h1);
        tick();
        a_resp_valid = 1'b0;
        check("late_uflow", underflow, 1);
        check("late_cnt", cnt, 0);
        check("late_resp_vld", resp_vld, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
